seg7_scan_decoder: RTL

- Receiver for a multiplexed, active-low 7-segment digit bus, the inverse of our hex-to-segment display encoder.
- Samples one digit pattern per strobe and decodes it back to a 4-bit hex nibble.
- Assembles DIGITS nibbles into a frame and publishes the value once FRAMES_MATCH consecutive identical frames have been captured.
- Used in loopback self-checks of the display path and to read external scanned displays.

---
 rtl/seg7_scan_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Scanned active-low 7-segment bus receiver: decodes strobed digits into a frame and publishes it
// once FRAMES_MATCH identical frames arrive. Define SEG7_ALT_GLYPH_EN to accept the alternate 7 and 9 glyphs.
module seg7_scan_decoder #(
    parameter int DIGITS       = 4,
    parameter int FRAMES_MATCH = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [6:0]            SEG,
    input  logic [DIGITS-1:0]     DIG,
    input  logic                  STB,
    input  logic                  CLR,
    output logic [4*DIGITS-1:0]   VAL,
    output logic                  VALID,
    output logic                  LOCK,
    output logic                  ERR
);

    localparam int                VW        = 4 * DIGITS;
    localparam logic [DIGITS-1:0] ALL_SEEN  = '1;
    localparam logic [3:0]        MATCH_TGT = 4'(FRAMES_MATCH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK
    } state_e;

    // Returns {pattern_valid, nibble}; patterns are active-low, bit0 = segment a.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
`ifdef SEG7_ALT_GLYPH_EN
            7'h58:   return {1'b1, 4'h7};
            7'h18:   return {1'b1, 4'h9};
`endif
            default: return 5'h00;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                bad_q, bad_d;
    logic [3:0]          match_q, match_d;
    logic [VW-1:0]       shadow_q;
    logic [VW-1:0]       prev_q;
    logic [VW-1:0]       val_q;
    logic                valid_q;
    logic                lock_q;
    logic                err_q;

    logic [4:0]          dec;
    logic                pat_ok;
    logic [3:0]          nib;
    logic                one_hot;
    logic                take;
    logic                at_check;
    logic                err_set;
    logic                publish;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        dec      = decode(SEG);
        pat_ok   = dec[4];
        nib      = dec[3:0];
        one_hot  = (DIG != '0) && ((DIG & (DIG - DIGITS'(1))) == '0);
        take     = STB && one_hot;
        at_check = (state_q == CHECK);
        err_set  = STB && (!one_hot || !pat_ok);

        // A sample on the CHECK cycle starts the next frame, so the old mask is dropped first.
        seen_d = (at_check ? '0 : seen_q) | (take ? DIG : '0);
        bad_d  = (at_check ? 1'b0 : bad_q) | (take && !pat_ok);

        if (take && (seen_d == ALL_SEEN)) begin
            state_d = CHECK;
        end else if (take) begin
            state_d = COLLECT;
        end else if (at_check) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end

        if (shadow_q != prev_q) begin
            match_d = 4'd1;
        end else if (match_q == 4'hF) begin
            match_d = 4'hF;
        end else begin
            match_d = match_q + 4'd1;
        end

        publish = at_check && !bad_q && (match_d == MATCH_TGT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            seen_q  <= '0;
            bad_q   <= 1'b0;
            match_q <= '0;
            prev_q  <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (CLR) begin
                state_q <= IDLE;
                seen_q  <= '0;
                bad_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                seen_q  <= seen_d;
                bad_q   <= bad_d;
                if (err_set) begin
                    err_q <= 1'b1;
                end
                if (at_check) begin
                    if (bad_q) begin
                        match_q <= '0;
                        lock_q  <= 1'b0;
                    end else begin
                        match_q <= match_d;
                        prev_q  <= shadow_q;
                        if (publish) begin
                            val_q   <= shadow_q;
                            valid_q <= 1'b1;
                            lock_q  <= 1'b1;
                        end else if (shadow_q != val_q) begin
                            lock_q  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // NOTE: the shadow frame needs no reset; every slot is rewritten before a frame can complete.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (take && pat_ok && !CLR && DIG[i]) begin
                shadow_q[4*i +: 4] <= nib;
            end
        end
    end

    assign VAL   = val_q;
    assign VALID = valid_q;
    assign LOCK  = lock_q;
    assign ERR   = err_q;

endmodule
